// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and FSM state type for the serial-to-parallel
// frame capture block.
//   N_CH  - number of output channels (frame width in bits)
//   SEL_W - width of the channel index
//   state_t - capture FSM states
package demux_pkg;

  localparam int N_CH  = 13;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage : demux_pkg

// File: rtl/mod13_counter.sv
// mod13_counter: channel index counter that runs 0..N_CH-1 and wraps to 0.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   clr        - synchronous clear to 0 (wins over en)
//   en         - advance the index by one
//   count      - current index, never outside 0..N_CH-1
//   wrap       - high in the cycle an enabled step leaves index N_CH-1
module mod13_counter
  import demux_pkg::*;
#(
  parameter int N_CH  = demux_pkg::N_CH,
  parameter int SEL_W = demux_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [SEL_W-1:0] count,
  output logic             wrap
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0] count_q;
  logic [SEL_W-1:0] count_d;

  // Next index: clear, hold, step, or fold back from the last channel.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (count_q == LAST) begin
        count_d = '0;
      end else begin
        count_d = count_q + SEL_W'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = en & ~clr & (count_q == LAST);

endmodule : mod13_counter

// File: rtl/demux13_capture.sv
// demux13_capture: captures N_CH serial bits into a shadow register and
// publishes the completed frame on a registered parallel output.
// Ports:
//   clk, rst_n     - clock and asynchronous active-low reset
//   start          - begin a frame (accepted only in IDLE)
//   abort          - drop the frame in progress, back to IDLE
//   din, din_valid - serial data and its qualifier
//   o, o_valid     - last complete frame and its one-cycle update pulse
//   busy           - high while capturing
//   s              - channel the next valid bit is written to
module demux13_capture
  import demux_pkg::*;
#(
  parameter int N_CH  = demux_pkg::N_CH,
  parameter int SEL_W = demux_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             din,
  input  logic             din_valid,
  output logic [N_CH-1:0]  o,
  output logic             o_valid,
  output logic             busy,
  output logic [SEL_W-1:0] s
);

  state_t           state_q;
  logic [N_CH-1:0]  shadow_q;
  logic [N_CH-1:0]  o_q;
  logic             o_valid_q;
  logic             busy_q;

  logic [SEL_W-1:0] idx_s;
  logic             wrap_s;
  logic             accept_s;
  logic             cnt_clr_s;

  // Bit acceptance and index control; outside CAPTURE the index is held at 0.
  always_comb begin
    accept_s  = 1'b0;
    cnt_clr_s = 1'b1;
    if ((state_q == CAPTURE) && !abort) begin
      accept_s  = din_valid;
      cnt_clr_s = 1'b0;
    end else begin
      accept_s  = 1'b0;
      cnt_clr_s = 1'b1;
    end
  end

  mod13_counter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_s),
    .en    (accept_s),
    .count (idx_s),
    .wrap  (wrap_s)
  );

  // Capture FSM with shadow register and registered frame outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      o_valid_q <= 1'b0;
      if (abort) begin
        // Abort wins over completion: the output keeps the previous frame.
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q <= CAPTURE;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          CAPTURE: begin
            if (accept_s) begin
              shadow_q[idx_s] <= din;
            end
            if (wrap_s) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= CAPTURE;
              busy_q  <= 1'b1;
            end
          end
          DONE: begin
            // Shadow already holds the final bit written on the previous edge.
            o_q       <= shadow_q;
            o_valid_q <= 1'b1;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o       = o_q;
  assign o_valid = o_valid_q;
  assign busy    = busy_q;
  assign s       = idx_s;

endmodule : demux13_capture

// File: tb/tb_demux13_capture.sv
// Bench for demux13_capture: reference model of the frame rules, scoreboard
// of expected frames, and a negedge monitor comparing every cycle.
module tb_demux13_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic [12:0] o;
  logic        o_valid;
  logic        busy;
  logic [3:0]  s;

  int total = 0;
  int bad = 0;
  int ov_count = 0;

  demux13_capture dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .din       (din),
    .din_valid (din_valid),
    .o         (o),
    .o_valid   (o_valid),
    .busy      (busy),
    .s         (s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Bench-side 13:1 selector: returns channel sel of a 13-bit word.
  function automatic logic mux13(input logic [12:0] v, input logic [3:0] sel);
    if (sel < 4'd13) return v[sel];
    return 1'b0;
  endfunction

  // ---------------- reference model ----------------
  // A frame is a list of collected bits; index = number collected so far.
  logic        m_cap = 1'b0;
  logic        m_done = 1'b0;
  logic [12:0] m_o = 13'd0;
  logic        m_ov = 1'b0;
  logic [12:0] m_f;
  bit          m_bits[$];
  logic [12:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cap = 1'b0; m_done = 1'b0; m_o = 13'd0; m_ov = 1'b0;
      m_bits.delete(); exp_q.delete();
    end else begin
      m_ov = 1'b0;
      if (abort) begin
        m_cap = 1'b0; m_done = 1'b0; m_bits.delete();
      end else if (m_done) begin
        for (int k = 0; k < 13; k++) m_f[k] = m_bits[k];
        m_o = m_f; m_ov = 1'b1; exp_q.push_back(m_f);
        m_done = 1'b0; m_bits.delete();
      end else if (m_cap) begin
        if (din_valid) begin
          m_bits.push_back(din);
          if (m_bits.size() == 13) begin
            m_cap = 1'b0; m_done = 1'b1;
          end
        end
      end else if (start) begin
        m_cap = 1'b1; m_bits.delete();
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("s", 32'(s), m_cap ? 32'(m_bits.size()) : 32'd0);
      chk("s_range", 32'(s <= 4'd12), 32'd1);
      chk("busy", 32'(busy), 32'(m_cap));
      chk("o_valid", 32'(o_valid), 32'(m_ov));
      chk("o_hold", 32'(o), 32'(m_o));
      if (o_valid) begin
        ov_count++;
        chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("sb_frame", 32'(o), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic st, input logic ab, input logic d, input logic dv);
    @(negedge clk);
    start = st; abort = ab; din = d; din_valid = dv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'($urandom), 1'($urandom));
  endtask

  // Start, then send nb bits of f; cycles listed in stalls carry din_valid=0.
  task automatic send(input logic [12:0] f, input int nb, input int st0, input int st1,
                      input int st2, input logic hold_start);
    int k = 0;
    int c = 1;
    drive(1'b1, 1'b0, 1'($urandom), 1'b1);
    while (k < nb) begin
      if (c == st0 || c == st1 || c == st2) begin
        drive(hold_start, 1'b0, 1'($urandom), 1'b0);
      end else begin
        drive(hold_start, 1'b0, f[k], 1'b1);
        k++;
      end
      c++;
    end
  endtask

  logic [12:0] frm;
  int          ov_before;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o", 32'(o), 32'd0);
    chk("rst_ov", 32'(o_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame, then mux sweep over the channel index
    frm = 13'b1010011101110;
    send(frm, 13, 0, 0, 0, 1'b0);
    idle(4);
    for (int k = 0; k < 13; k++) chk("mux_sweep", 32'(mux13(o, 4'(k))), 32'(frm[k]));

    // Same frame with stalls
    send(frm, 13, 3, 4, 9, 1'b0);
    idle(4);

    // Abort after 7 bits, then all-ones frame
    send(13'h0A5A, 7, 0, 0, 0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    idle(2);
    chk("abort_keep_o", 32'(o), 32'(frm));
    send(13'h1FFF, 13, 0, 0, 0, 1'b0);
    idle(4);
    chk("ones_frame", 32'(o), 32'h1FFF);

    // abort together with start in IDLE stays idle
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Asynchronous reset mid-frame
    send(13'h1555, 5, 0, 0, 0, 1'b0);
    @(posedge clk);
    din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_o", 32'(o), 32'd0);
    chk("arst_s", 32'(s), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    #1 rst_n = 1'b1;
    idle(3);
    send(13'h0001, 13, 0, 0, 0, 1'b0);
    idle(4);
    chk("one_frame", 32'(o), 32'h0001);

    // start held through the frame and the DONE cycle
    ov_before = ov_count;
    send(13'h0F3C, 13, 0, 0, 0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("held_start_pulses", 32'(ov_count - ov_before), 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 59) == 0),
            1'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_demux13_capture

// File: doc/demux13_capture.md
DEMUX13_CAPTURE -- requirements
Module: demux13_capture

Interface
REQ-001 Parameter N_CH, default 13, number of output channels (frame width).
REQ-002 Parameter SEL_W, default 4, width of the channel index.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low; one clock domain only.
REQ-005 start  input  1  single-cycle request to begin capturing a frame.
REQ-006 abort  input  1  discards the frame in progress and returns the block to idle.
REQ-007 din  input  1  serial data bit.
REQ-008 din_valid  input  1  din is valid this cycle.
REQ-009 o  output  N_CH  last completed parallel frame, registered.
REQ-010 o_valid  output  1  one-cycle pulse: o was updated with a new frame.
REQ-011 busy  output  1  high while in CAPTURE.
REQ-012 s  output  SEL_W  channel index the next valid din is written to.

Function
REQ-013 The block SHALL implement a 3-state FSM: IDLE, CAPTURE, DONE.
REQ-014 In IDLE, start=1 SHALL move the FSM to CAPTURE and set s=0; din/din_valid in that same cycle SHALL be ignored.
REQ-015 In CAPTURE, each cycle with din_valid=1 SHALL write din into shadow[s] and increment s by 1.
REQ-016 din_valid=0 SHALL hold s and the shadow register (stall, no timeout).
REQ-017 A valid bit accepted at s=N_CH-1 SHALL complete the frame and move the FSM to DONE.
REQ-018 In DONE (one cycle), o SHALL load shadow with bit N_CH-1 = that final din, o_valid SHALL be 1, and the FSM SHALL return to IDLE with s=0.
REQ-019 Latency SHALL be: o and o_valid change on the edge following the edge that sampled the 13th valid bit.
REQ-020 Bit ordering SHALL be: the first valid bit goes to o[0] and the last to o[N_CH-1] (channel s maps to o[s]).
REQ-021 s SHALL never take a value from N_CH to 2^SEL_W-1; it wraps from N_CH-1 to 0 only through DONE.
REQ-022 start SHALL be ignored in CAPTURE and DONE.
REQ-023 start in the DONE cycle SHALL NOT start a new frame; start is accepted again from the following IDLE cycle.
REQ-024 abort SHALL take priority over din_valid and completion in any state: next state IDLE, s=0, o unchanged, o_valid=0.
REQ-025 abort and start together in IDLE SHALL leave the FSM in IDLE.
REQ-026 o SHALL hold its value between frames; partial frames SHALL never appear on o.
REQ-027 busy SHALL equal (state==CAPTURE).

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for a clock edge, force: state=IDLE, s=0, o=0, o_valid=0, busy=0, shadow=0.
REQ-029 Reset asserted mid-capture SHALL discard the partial frame; after release the block SHALL wait for a new start.
REQ-030 The first edge after rst_n rises SHALL be treated as a normal IDLE cycle.

Structure
REQ-031 A shared package demux_pkg SHALL hold N_CH=13, SEL_W=4 and the FSM state type (IDLE, CAPTURE, DONE).
REQ-032 The index SHALL be a sub-module mod13_counter with clk, rst_n, clr, en, count[SEL_W-1:0] and wrap pulse at N_CH-1.
REQ-033 The FSM, shadow register and output register SHALL live in demux13_capture.

Verification
REQ-034 Reset then start, then 13 consecutive valid bits forming 13'b1010011101110 LSB-first -> one cycle later o=13'b1010011101110, o_valid high for exactly 1 cycle, busy low.
REQ-035 Same frame with din_valid=0 on cycles 3, 4 and 9 -> identical o; o_valid delayed by 3 cycles; s holds during stalls.
REQ-036 Start, 7 valid bits, then abort -> o unchanged from the previous frame, no o_valid, s=0; a following full frame of 13'h1FFF -> o=13'h1FFF.
REQ-037 rst_n pulsed low asynchronously (between edges) after 5 bits -> o=0 and s=0 immediately; a later full frame of 13'h0001 -> o=13'h0001.
REQ-038 start held high through a whole frame -> exactly one o_valid; s steps 0..12 and never shows 13-15; start in the DONE cycle is ignored.
REQ-039 A bench checker SHALL feed o through the team's 13:1 mux with s swept 0..12 and confirm mux output == serial bit k.
